// File: rtl/pps_pkg.sv
// pps_pkg: shared state type and phase-width helper for the pps generator and receiver
package pps_pkg;
   typedef enum logic [1:0] {IDLE, ARM, RUN} pps_gen_state_t;
   function automatic int pps_phase_width(input int freq);
      return $clog2(freq);
   endfunction
endpackage

// File: rtl/pps_if.sv
// pps_if: fabric control channel for phase steps, phase loads and seconds preset
interface pps_if #(parameter int W = pps_pkg::pps_phase_width(125000000));
   logic         adj_valid;
   logic         adj_adv;
   logic         adj_ready;
   logic         load_valid;
   logic [W-1:0] load_phase;
   logic         load_ready;
   logic         tod_valid;
   logic [31:0]  tod_value;
   modport master (
      output adj_valid, adj_adv, load_valid, load_phase, tod_valid, tod_value,
      input  adj_ready, load_ready
   );
   modport slave (
      input  adj_valid, adj_adv, load_valid, load_phase, tod_valid, tod_value,
      output adj_ready, load_ready
   );
endinterface

// File: rtl/pps_phase_counter.sv
// pps_phase_counter: per-second phase counter with one-tick steps and absolute loads
module pps_phase_counter import pps_pkg::*; #(
   parameter int F = 125000000,
   parameter int W = pps_phase_width(F)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         adj_valid,
   input  logic         adj_adv,
   output logic         adj_ready,
   input  logic         load_valid,
   input  logic [W-1:0] load_phase,
   output logic         load_ready,
   output logic         load_acc,
   output logic [W-1:0] phase_cnt,
   output logic         wrap
);
   localparam logic [W-1:0] LAST = W'(F - 1);
   localparam logic [W-1:0] MID = W'(F / 2);
   logic         pend, adv, apply, adj_acc;
   logic [W-1:0] inc, nxt;
   assign adj_ready = !pend;
   assign load_ready = !pend;
   assign load_acc = load_valid && load_ready;
   assign adj_acc = adj_valid && adj_ready && !load_acc;
   assign apply = pend && phase_cnt == MID;
   assign wrap = phase_cnt == LAST;
   // steps land mid-second so they never disturb the pulse
   always_comb begin
      inc = wrap ? '0 : phase_cnt + W'(1);
      nxt = load_acc ? (load_phase > LAST ? LAST : load_phase) :
            !apply   ? inc :
            adv      ? (inc == LAST ? '0 : inc + W'(1)) : phase_cnt;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         phase_cnt <= '0;
         pend <= 1'b0;
         adv <= 1'b0;
      end else begin
         phase_cnt <= nxt;
         pend <= adj_acc || (pend && !apply);
         if (adj_acc) adv <= adj_adv;
      end
   end
endmodule

// File: rtl/pps_generator_top.sv
// pps_generator_top: local 1PPS source with phase steering and a seconds counter
module pps_generator_top import pps_pkg::*; #(
   parameter int C_CLOCK_FREQUENCY = 125000000,
   parameter int C_PULSE_WIDTH = 12500000,
   localparam int W = pps_phase_width(C_CLOCK_FREQUENCY)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         enable,
   pps_if.slave         ctl,
   output logic         pps_out,
   output logic         pps_tick,
   output logic [31:0]  sec_count,
   output logic [W-1:0] phase,
   output logic         running
);
   localparam logic [W-1:0] PW = W'(C_PULSE_WIDTH);
   pps_gen_state_t state, state_n;
   logic         load_acc, wrap, stay, tick_n, tod_pend;
   logic [31:0]  tod_hold;
   logic [W-1:0] phase_cnt;
   pps_phase_counter #(.F(C_CLOCK_FREQUENCY), .W(W)) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .adj_valid  (ctl.adj_valid),
      .adj_adv    (ctl.adj_adv),
      .adj_ready  (ctl.adj_ready),
      .load_valid (ctl.load_valid),
      .load_phase (ctl.load_phase),
      .load_ready (ctl.load_ready),
      .load_acc   (load_acc),
      .phase_cnt  (phase_cnt),
      .wrap       (wrap)
   );
   // a load re-arms, so the pulse only resumes at the next natural wrap
   always_comb begin
      state_n = !enable ? IDLE :
                (state == IDLE || load_acc) ? ARM :
                (state == ARM && wrap) ? RUN : state;
      stay = state == RUN && state_n == RUN;
      tick_n = stay && phase_cnt == '0;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         pps_out <= 1'b0;
         pps_tick <= 1'b0;
         sec_count <= '0;
         phase <= '0;
         running <= 1'b0;
         tod_pend <= 1'b0;
         tod_hold <= '0;
      end else begin
         state <= state_n;
         pps_out <= stay && phase_cnt < PW;
         pps_tick <= tick_n;
         phase <= phase_cnt;
         running <= state == RUN;
         if (tick_n) begin
            sec_count <= tod_pend ? tod_hold : sec_count + 32'd1;
            tod_pend <= 1'b0;
         end
         if (ctl.tod_valid) begin
            tod_pend <= 1'b1;
            tod_hold <= ctl.tod_value;
         end
      end
   end
endmodule

// File: tb/tb_pps_generator_top.sv
// tb_pps_generator_top: scenario and randomized checks against a per-second reference model
module tb_pps_generator_top;
   localparam int F = 100, PW = 10, W = 7;
   localparam int S_IDLE = 0, S_ARM = 1, S_RUN = 2;
   logic clk = 0, rst = 1, enable = 0;
   logic pps_out, pps_tick, running;
   logic [31:0] sec_count;
   logic [W-1:0] phase;
   pps_if #(.W(W)) ctl ();
   pps_generator_top #(.C_CLOCK_FREQUENCY(F), .C_PULSE_WIDTH(PW)) dut (
      .clk(clk), .rst(rst), .enable(enable), .ctl(ctl), .pps_out(pps_out),
      .pps_tick(pps_tick), .sec_count(sec_count), .phase(phase), .running(running)
   );
   always #5 clk = ~clk;
   int m_phase, m_state, m_phase_q, cyc, n_vec, n_err;
   bit m_pend, m_adv, m_tod_pend, m_out, m_tick, m_run;
   logic [31:0] m_sec, m_tod;
   logic [43:0] obs, exp_v;
   localparam logic [43:0] RST_V = {3'b000, 2'b11, 32'd0, 7'd0};
   assign obs = {pps_out, pps_tick, running, ctl.adj_ready, ctl.load_ready, sec_count, phase};
   always_comb exp_v = {m_out, m_tick, m_run, !m_pend, !m_pend, m_sec, W'(m_phase_q)};
   // one clock of the second-level behaviour, from the inputs seen at the edge
   task automatic model_step();
      bit la, aa, app, keep;
      if (rst) begin
         m_phase = 0; m_state = S_IDLE; m_pend = 0; m_tod_pend = 0;
         m_out = 0; m_tick = 0; m_run = 0; m_sec = 0; m_phase_q = 0;
         return;
      end
      la = ctl.load_valid && !m_pend;
      aa = ctl.adj_valid && !m_pend && !la;
      app = m_pend && m_phase == F / 2;
      keep = m_state == S_RUN && enable && !la;
      m_out = keep && m_phase < PW;
      m_tick = keep && m_phase == 0;
      m_run = m_state == S_RUN;
      m_phase_q = m_phase;
      if (m_tick) begin m_sec = m_tod_pend ? m_tod : m_sec + 1; m_tod_pend = 0; end
      if (ctl.tod_valid) begin m_tod_pend = 1; m_tod = ctl.tod_value; end
      if (!enable) m_state = S_IDLE;
      else if (m_state == S_IDLE || la) m_state = S_ARM;
      else if (m_state == S_ARM && m_phase == F - 1) m_state = S_RUN;
      m_phase = la ? (int'(ctl.load_phase) >= F ? F - 1 : int'(ctl.load_phase)) :
                app ? (m_phase + (m_adv ? 2 : 0)) % F : (m_phase + 1) % F;
      if (aa) begin m_pend = 1; m_adv = ctl.adj_adv; end
      else if (app) m_pend = 0;
   endtask
   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      cyc++;
   endtask
   task automatic test_reset();
      rst = 1; enable = 0;
      ctl.adj_valid = 0; ctl.adj_adv = 0; ctl.load_valid = 0; ctl.load_phase = 0;
      ctl.tod_valid = 0; ctl.tod_value = 0;
      repeat (3) cycle();
      n_vec++; if (obs !== RST_V) begin n_err++; $display("FAIL reset got=%h exp=%h", obs, RST_V); end
      n_vec++; if (obs !== exp_v) begin n_err++; $display("FAIL reset_model got=%h exp=%h", obs, exp_v); end
      rst = 0;
   endtask
   task automatic test_run();
      int last = -1, highs = 0, nt = 0;
      enable = 1;
      repeat (330) begin
         cycle();
         n_vec++; if (obs !== exp_v) begin n_err++; $display("FAIL run_model cyc=%0d got=%h exp=%h", cyc, obs, exp_v); end
         if (pps_tick) begin
            nt++;
            n_vec++; if (phase !== 0 || sec_count !== nt) begin n_err++; $display("FAIL run_tick phase=%0d sec=%0d exp phase=0 sec=%0d", phase, sec_count, nt); end
            if (last >= 0) begin
               n_vec++; if (cyc - last !== F || highs !== PW) begin n_err++; $display("FAIL run_period period=%0d high=%0d exp %0d/%0d", cyc - last, highs, F, PW); end
            end
            last = cyc; highs = 0;
         end
         highs += int'(pps_out);
      end
      n_vec++; if (nt !== 3) begin n_err++; $display("FAIL run_ticks got=%0d exp=3", nt); end
   endtask
   task automatic test_step(input bit adv);
      int t0 = -1, t1 = -1, t2 = -1, lat = 0;
      for (int i = 0; i < 2 * F && t0 < 0; i++) begin cycle(); if (pps_tick) t0 = cyc; end
      repeat (10 + $urandom_range(0, 20)) cycle();
      ctl.adj_valid = 1; ctl.adj_adv = adv;
      cycle();
      ctl.adj_valid = 0; ctl.adj_adv = 1'($urandom_range(0, 1));
      n_vec++; if (ctl.adj_ready !== 0 || ctl.load_ready !== 0) begin n_err++; $display("FAIL step_accept adj_ready=%b load_ready=%b exp 0/0", ctl.adj_ready, ctl.load_ready); end
      while (!ctl.adj_ready && lat < 2 * F) begin cycle(); lat++; end
      n_vec++; if (ctl.adj_ready !== 1 || phase !== F / 2) begin n_err++; $display("FAIL step_release ready=%b phase=%0d exp 1/%0d", ctl.adj_ready, phase, F / 2); end
      for (int i = 0; i < 3 * F && t2 < 0; i++) begin
         cycle();
         n_vec++; if (obs !== exp_v) begin n_err++; $display("FAIL step_model cyc=%0d got=%h exp=%h", cyc, obs, exp_v); end
         if (pps_tick) begin if (t1 < 0) t1 = cyc; else t2 = cyc; end
      end
      n_vec++;
      if (t0 < 0 || t2 < 0 || t1 - t0 !== (adv ? F - 1 : F + 1) || t2 - t1 !== F) begin
         n_err++; $display("FAIL step_period adv=%b periods=%0d,%0d exp %0d,%0d", adv, t1 - t0, t2 - t1, adv ? F - 1 : F + 1, F);
      end
   endtask
   task automatic test_load();
      int p, acc, tk = -1, rt;
      logic [31:0] s0;
      rt = $urandom_range(2, 8);
      for (int i = 0; i < 2 * F && !(running && phase == W'(rt)); i++) cycle();
      p = $urandom_range(60, 95); s0 = sec_count;
      ctl.load_valid = 1; ctl.load_phase = W'(p);
      cycle();
      ctl.load_valid = 0; acc = cyc;
      n_vec++; if (pps_out !== 0 || obs !== exp_v) begin n_err++; $display("FAIL load_force pps_out=%b got=%h exp=%h", pps_out, obs, exp_v); end
      for (int i = 0; i < 2 * F && tk < 0; i++) begin
         cycle();
         if (i == 0) begin
            n_vec++; if (phase !== W'(p) || running !== 0) begin n_err++; $display("FAIL load_phase phase=%0d running=%b exp %0d/0", phase, running, p); end
         end
         if (pps_tick) tk = cyc;
      end
      n_vec++; if (tk - acc !== 101 - p || sec_count !== s0 + 32'd1) begin n_err++; $display("FAIL load_tick delay=%0d sec=%0d exp %0d/%0d", tk - acc, sec_count, 101 - p, s0 + 32'd1); end
      ctl.load_valid = 1; ctl.load_phase = W'($urandom_range(F, 127));
      cycle();
      ctl.load_valid = 0;
      cycle();
      n_vec++; if (phase !== W'(F - 1) || pps_tick !== 0) begin n_err++; $display("FAIL load_clamp phase=%0d tick=%b exp %0d/0", phase, pps_tick, F - 1); end
      cycle();
      n_vec++; if (pps_tick !== 1 || obs !== exp_v) begin n_err++; $display("FAIL clamp_tick tick=%b got=%h exp=%h", pps_tick, obs, exp_v); end
   endtask
   task automatic test_tod();
      logic [31:0] vals[2];
      logic [31:0] want;
      int nt;
      vals[0] = $urandom; vals[1] = 32'hFFFF_FFFF;
      foreach (vals[k]) begin
         for (int i = 0; i < 2 * F && phase < 40; i++) cycle();
         ctl.tod_valid = 1; ctl.tod_value = vals[k];
         cycle();
         ctl.tod_valid = 0; ctl.tod_value = $urandom;
         nt = 0; want = vals[k];
         for (int i = 0; i < 3 * F && nt < 2; i++) begin
            cycle();
            if (pps_tick) begin
               n_vec++; if (sec_count !== want) begin n_err++; $display("FAIL tod_tick%0d sec=%h exp=%h", nt, sec_count, want); end
               want = want + 32'd1; nt++;
            end
         end
         n_vec++; if (nt !== 2) begin n_err++; $display("FAIL tod_ticks got=%0d exp=2", nt); end
      end
      for (int i = 0; i < 2 * F && !(pps_out && phase == 5); i++) cycle();
      enable = 0;
      cycle();
      n_vec++; if (pps_out !== 0 || obs !== exp_v) begin n_err++; $display("FAIL disable_pulse pps_out=%b got=%h exp=%h", pps_out, obs, exp_v); end
      cycle();
      n_vec++; if (running !== 0) begin n_err++; $display("FAIL disable_running got=%b exp=0", running); end
      enable = 1;
   endtask
   task automatic test_simul();
      int p;
      for (int i = 0; i < 2 * F && !(ctl.adj_ready && ctl.load_ready); i++) cycle();
      p = $urandom_range(0, F - 1);
      ctl.load_valid = 1; ctl.adj_valid = 1; ctl.adj_adv = 1; ctl.load_phase = W'(p);
      cycle();
      ctl.load_valid = 0; ctl.adj_valid = 0;
      n_vec++; if (ctl.adj_ready !== 1 || ctl.load_ready !== 1) begin n_err++; $display("FAIL simul_ready adj=%b load=%b exp 1/1", ctl.adj_ready, ctl.load_ready); end
      cycle();
      n_vec++; if (phase !== W'(p) || obs !== exp_v) begin n_err++; $display("FAIL simul_phase phase=%0d exp=%0d got=%h model=%h", phase, p, obs, exp_v); end
      p = $urandom_range(0, F - 1);
      ctl.load_valid = 1; ctl.load_phase = W'(p); enable = 0;
      cycle();
      ctl.load_valid = 0; enable = 1;
      cycle();
      n_vec++; if (phase !== W'(p) || running !== 0 || obs !== exp_v) begin n_err++; $display("FAIL load_disable phase=%0d running=%b exp %0d/0", phase, running, p); end
      for (int i = 0; i < 3 * F && !pps_out; i++) cycle();
      n_vec++; if (pps_out !== 1) begin n_err++; $display("FAIL rst_setup pps_out=%b exp=1", pps_out); end
      rst = 1;
      cycle();
      rst = 0;
      n_vec++; if (obs !== RST_V) begin n_err++; $display("FAIL rst_mid got=%h exp=%h", obs, RST_V); end
   endtask
   task automatic test_random();
      enable = 1;
      repeat (3000) begin
         if ($urandom_range(0, 299) == 0) enable = !enable;
         rst = $urandom_range(0, 1999) == 0;
         ctl.adj_valid = $urandom_range(0, 39) == 0;
         ctl.adj_adv = 1'($urandom_range(0, 1));
         ctl.load_valid = $urandom_range(0, 149) == 0;
         ctl.load_phase = W'($urandom_range(0, 127));
         ctl.tod_valid = $urandom_range(0, 99) == 0;
         ctl.tod_value = $urandom;
         cycle();
         n_vec++; if (obs !== exp_v) begin n_err++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs, exp_v); end
      end
      rst = 0; ctl.adj_valid = 0; ctl.load_valid = 0; ctl.tod_valid = 0;
   endtask
   initial begin
      test_reset();
      test_run();
      test_step(1);
      test_step(0);
      test_load();
      test_tod();
      test_simul();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
